// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch, data-read and byte-write clients onto one byte-wide RAM/IO bus.
// Reads are serialised into byte cycles and reassembled little-endian; writes pass straight through.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_r_wait_o,
    output logic              i_done_o,
    output logic [31:0]       i_data_o,
    input  logic              d_read_i,
    input  logic [2:0]        d_len_i,
    input  logic              d_sign_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_r_wait_o,
    output logic              d_r_done_o,
    output logic [31:0]       d_r_data_o,
    input  logic              w_write_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [7:0]        w_data_i,
    output logic              w_wait_o,
    output logic              writting_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {IDLE, READ} state_t;

    state_t             state;
    logic               cli_d;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   len;
    logic               sign;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  asm_q;
    logic [DATA_W-1:0]  asm_next;
    logic [DATA_W-1:0]  result;
    logic               busy;
    logic               io_blocked;
    logic               w_go;
    logic               d_go;
    logic               i_go;

    // Arbitration: write > data read > fetch; everything stalls while a read is in flight.
    assign busy       = (state == READ);
    assign io_blocked = (w_addr_i[17:16] == IO_SEL) && io_buffer_full;
    assign w_wait_o   = rst | busy | io_blocked;
    assign d_r_wait_o = rst | busy | w_write_i;
    assign i_r_wait_o = rst | busy | w_write_i | d_read_i;
    assign w_go       = w_write_i & ~w_wait_o;
    assign d_go       = d_read_i & ~d_r_wait_o;
    assign i_go       = i_read_i & ~i_r_wait_o;

    // Bus drive: accepted write passes through, otherwise the read address phase.
    always_comb begin
        mem_wr     = 1'b0;
        mem_a      = '0;
        mem_dout   = '0;
        writting_o = 1'b0;
        if (w_go) begin
            mem_wr     = 1'b1;
            mem_a      = w_addr_i;
            mem_dout   = w_data_i;
            writting_o = 1'b1;
        end else if (busy && !rst && (cnt < len)) begin
            mem_a = base + ADDR_W'(cnt);
        end
    end

    // RAM latency is one cycle, so byte (cnt-1) is on mem_din now.
    always_comb begin
        asm_next = asm_q;
        case (cnt)
            3'd1:    asm_next[7:0]   = mem_din;
            3'd2:    asm_next[15:8]  = mem_din;
            3'd3:    asm_next[23:16] = mem_din;
            3'd4:    asm_next[31:24] = mem_din;
            default: ;
        endcase
    end

    always_comb begin
        result = asm_next;
        if (sign) begin
            if (len == 3'd1)      result[31:8]  = {24{asm_next[7]}};
            else if (len == 3'd2) result[31:16] = {16{asm_next[15]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cli_d      <= 1'b0;
            base       <= '0;
            len        <= '0;
            sign       <= 1'b0;
            cnt        <= '0;
            asm_q      <= '0;
            i_done_o   <= 1'b0;
            d_r_done_o <= 1'b0;
            i_data_o   <= '0;
            d_r_data_o <= '0;
        end else begin
            i_done_o   <= 1'b0;
            d_r_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_go) begin
                        state <= READ;
                        cli_d <= 1'b1;
                        base  <= d_addr_i;
                        len   <= (d_len_i == 3'd1 || d_len_i == 3'd2) ? d_len_i : 3'd4;
                        sign  <= d_sign_i;
                        cnt   <= '0;
                        asm_q <= '0;
                    end else if (i_go) begin
                        state <= READ;
                        cli_d <= 1'b0;
                        base  <= i_addr_i;
                        len   <= 3'd4;
                        sign  <= 1'b0;
                        cnt   <= '0;
                        asm_q <= '0;
                    end
                end
                READ: begin
                    asm_q <= asm_next;
                    cnt   <= cnt + 3'd1;
                    if (cnt == len) begin
                        state <= IDLE;
                        if (cli_d) begin
                            d_r_done_o <= 1'b1;
                            d_r_data_o <= result;
                        end else begin
                            i_done_o <= 1'b1;
                            i_data_o <= result;
                        end
                    end
                end
            endcase
        end
    end

endmodule
